sram_req_bridge: RTL and testbench

- Upstream stage of the generic SRAM bank.
- Converts a valid/ready byte-addressed request stream from the core/interconnect into the bank's raw mem_ce/mem_we/mem_addr/mem_wdata port.
- Returns in-order responses through a small response FIFO.
- Implements byte-enable writes via read-modify-write, because the bank has no byte strobes.

---
 rtl/sram_req_bridge.sv | 191 +++++++++++++++++++
 tb/tb_sram_req_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_bridge.sv
// sram_req_bridge: converts a valid/ready byte-addressed request stream into
// the raw SRAM bank port and returns in-order responses through a small FIFO.
// Byte-enable writes are done as read-modify-write since the bank has no strobes.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_we, req_addr, req_wdata,
//   req_be                         request payload (byte address, byte enables)
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_err           response payload (rdata is 0 for writes/errors)
//   mem_ce, mem_we, mem_addr,
//   mem_wdata, mem_rdata           SRAM bank port (read data one cycle after ce)
module sram_req_bridge #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned SRAM_ADDR_WIDTH = 16,
    parameter int unsigned RESP_FIFO_DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_be,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       resp_err,
    output logic [SRAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_we,
    output logic                       mem_ce,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int unsigned PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CR_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } resp_t;

    state_t                     state;
    logic [SRAM_ADDR_WIDTH-1:0] saved_widx;
    logic [DATA_WIDTH-1:0]      saved_wdata;
    logic [BE_W-1:0]            saved_be;
    logic                       inflight;
    logic                       rd_pending;

    resp_t                      fifo_mem [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]           wptr;
    logic [PTR_W-1:0]           rptr;
    logic [CNT_W-1:0]           count;

    logic [SRAM_ADDR_WIDTH-1:0] widx;
    logic                       addr_err;
    logic                       be_full;
    logic                       be_none;
    logic [CR_W-1:0]            used;
    logic                       accept;
    logic                       acc_rd;
    logic                       acc_full;
    logic                       acc_part;
    logic                       rd_push;
    logic                       imm_push;
    logic                       pop;
    logic [1:0]                 num_push;
    logic [PTR_W-1:0]           wptr_inc;
    logic [DATA_WIDTH-1:0]      merged;
    resp_t                      rd_entry;
    resp_t                      imm_entry;
    resp_t                      head;

    // Request decode: word index and out-of-range detection
    assign widx     = SRAM_ADDR_WIDTH'(req_addr >> OFF_W);
    assign addr_err = (req_addr >> (SRAM_ADDR_WIDTH + OFF_W)) != '0;
    assign be_full  = &req_be;
    assign be_none  = (req_be == '0);

    // Credits cover both queued responses and a read whose data is still on its way
    assign used      = CR_W'(count) + CR_W'(inflight);
    assign req_ready = i_rst_n && (state == IDLE) && (used < CR_W'(RESP_FIFO_DEPTH));

    assign accept   = req_valid && req_ready;
    assign acc_rd   = accept && !addr_err && !req_we;
    assign acc_full = accept && !addr_err && req_we && be_full;
    assign acc_part = accept && !addr_err && req_we && !be_full && !be_none;

    // rd_pending separates a plain read (data is the response) from an RMW read
    assign rd_push  = inflight && rd_pending;
    assign imm_push = (accept && !acc_rd && !acc_part) || (state == RMW_WR);
    assign pop      = resp_valid && resp_ready;
    assign num_push = {1'b0, rd_push} + {1'b0, imm_push};
    assign wptr_inc = wptr + PTR_W'(1);

    assign rd_entry  = '{err: 1'b0, rdata: mem_rdata};
    assign imm_entry = '{err: accept && addr_err, rdata: '0};

    // Byte merge for the write half of an RMW
    always_comb begin
        merged = mem_rdata;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (saved_be[i]) begin
                merged[i*8 +: 8] = saved_wdata[i*8 +: 8];
            end
        end
    end

    // SRAM port: driven straight from the request in IDLE, from saved state in RMW_RD
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = widx;
        mem_wdata = req_wdata;
        if (state == RMW_RD) begin
            mem_addr  = saved_widx;
            mem_wdata = merged;
            mem_ce    = i_rst_n;
            mem_we    = i_rst_n;
        end else begin
            mem_ce = acc_rd || acc_full || acc_part;
            mem_we = acc_full;
        end
    end

    // Control FSM, read tracking and FIFO pointers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            saved_widx  <= '0;
            saved_wdata <= '0;
            saved_be    <= '0;
            inflight    <= 1'b0;
            rd_pending  <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
        end else begin
            inflight   <= acc_rd || acc_part;
            rd_pending <= acc_rd;
            case (state)
                IDLE: begin
                    if (acc_part) begin
                        saved_widx  <= widx;
                        saved_wdata <= req_wdata;
                        saved_be    <= req_be;
                        state       <= RMW_RD;
                    end
                end
                RMW_RD:  state <= RMW_WR;
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
            wptr  <= wptr + PTR_W'(num_push);
            rptr  <= rptr + PTR_W'(pop);
            count <= count + CNT_W'(num_push) - CNT_W'(pop);
        end
    end

    // FIFO storage; a returning read is older than a same-cycle immediate response
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (rd_push) begin
                fifo_mem[wptr] <= rd_entry;
            end
            if (imm_push) begin
                fifo_mem[rd_push ? wptr_inc : wptr] <= imm_entry;
            end
        end
    end

    // Response outputs come from the FIFO head, forced to zero when empty
    assign head       = fifo_mem[rptr];
    assign resp_valid = (count != '0);
    assign resp_rdata = resp_valid ? head.rdata : '0;
    assign resp_err   = resp_valid && head.err;

endmodule

// File: tb/tb_sram_req_bridge.sv
// Bench for sram_req_bridge: transaction-level model plus directed scenarios.
module tb_sram_req_bridge;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ce;
    logic [31:0] mem_rdata = 32'h0;

    sram_req_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_ADDR_WIDTH(16), .RESP_FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ce(mem_ce),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM bank: preloaded contents plus words written by the DUT
    bit [31:0] pre_mem [65536];
    bit [31:0] wr_mem  [65536];
    bit        wr_flag [65536];
    always @(posedge clk) begin
        if (mem_ce === 1'b1) begin
            if (mem_we === 1'b1) begin
                wr_mem[mem_addr]  <= mem_wdata;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr] ? wr_mem[mem_addr] : pre_mem[mem_addr];
            end
        end
    end

    typedef struct { int due; logic err; logic [31:0] data; } exp_t;
    typedef struct { int cyc; logic err; logic [31:0] data; } got_t;

    int        checks = 0;
    int        errors = 0;
    bit [31:0] ref_mem [65536];
    exp_t      q[$];
    got_t      got[$];
    int        busy_until = -1;
    bit        pw_valid = 1'b0;
    int        pw_cyc = 0;
    logic [15:0] pw_widx = '0;
    logic [31:0] pw_data = '0;
    bit        prev_rst_low = 1'b0;
    int        ce_cnt = 0;
    int        we_cnt = 0;
    logic [31:0] last_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        pre_mem[w] = d;
        ref_mem[w] = d;
    endtask

    // Model: every accepted request becomes an expected response with a due cycle
    task automatic model_loop();
        bit          exp_ready, exp_ce, exp_we, exp_valid, acc, oor;
        logic [15:0] w;
        logic [31:0] mask;
        forever begin
            @(negedge clk);
            if (mem_ce === 1'b1) ce_cnt++;
            if (mem_we === 1'b1) begin
                we_cnt++;
                last_wdata = mem_wdata;
            end
            if (!rst_n) begin
                chk("rst_req_ready", 32'(req_ready), 32'h0);
                chk("rst_mem_ce", 32'(mem_ce), 32'h0);
                chk("rst_mem_we", 32'(mem_we), 32'h0);
                if (prev_rst_low) begin
                    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
                    chk("rst_resp_err", 32'(resp_err), 32'h0);
                    chk("rst_resp_rdata", resp_rdata, 32'h0);
                end
                q.delete();
                pw_valid     = 1'b0;
                busy_until   = -1;
                prev_rst_low = 1'b1;
            end else begin
                prev_rst_low = 1'b0;
                exp_ready = (cyc > busy_until) && (q.size() < DEPTH);
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                acc = req_valid && exp_ready;
                w   = req_addr[17:2];
                oor = (req_addr[31:18] != 14'h0);
                exp_ce = 1'b0;
                exp_we = 1'b0;
                if (pw_valid && pw_cyc == cyc) begin
                    exp_ce = 1'b1;
                    exp_we = 1'b1;
                    chk("rmw_mem_addr", 32'(mem_addr), 32'(pw_widx));
                    chk("rmw_mem_wdata", mem_wdata, pw_data);
                    ref_mem[pw_widx] = pw_data;
                    pw_valid = 1'b0;
                end else if (acc && !oor && !(req_we && req_be == 4'h0)) begin
                    exp_ce = 1'b1;
                    exp_we = req_we && (req_be == 4'hF);
                    chk("mem_addr", 32'(mem_addr), 32'(w));
                    if (exp_we) chk("mem_wdata", mem_wdata, req_wdata);
                end
                chk("mem_ce", 32'(mem_ce), 32'(exp_ce));
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                exp_valid = (q.size() != 0) && (q[0].due <= cyc);
                chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
                if (exp_valid) begin
                    chk("resp_err", 32'(resp_err), 32'(q[0].err));
                    chk("resp_rdata", resp_rdata, q[0].data);
                    if (resp_ready) void'(q.pop_front());
                end
                if (resp_valid === 1'b1 && resp_ready)
                    got.push_back('{cyc: cyc, err: resp_err, data: resp_rdata});
                if (acc) begin
                    if (oor) begin
                        q.push_back('{due: cyc + 1, err: 1'b1, data: 32'h0});
                    end else if (!req_we) begin
                        q.push_back('{due: cyc + 2, err: 1'b0, data: ref_mem[w]});
                    end else if (req_be == 4'hF) begin
                        ref_mem[w] = req_wdata;
                        q.push_back('{due: cyc + 1, err: 1'b0, data: 32'h0});
                    end else if (req_be == 4'h0) begin
                        q.push_back('{due: cyc + 1, err: 1'b0, data: 32'h0});
                    end else begin
                        mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
                        pw_data    = (req_wdata & mask) | (ref_mem[w] & ~mask);
                        pw_widx    = w;
                        pw_cyc     = cyc + 1;
                        pw_valid   = 1'b1;
                        busy_until = cyc + 2;
                        q.push_back('{due: cyc + 3, err: 1'b0, data: 32'h0});
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns the accept cycle
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int acc);
        int n = 0;
        bit ok = 1'b0;
        acc       = -1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok  = 1'b1;
                acc = cyc;
            end else begin
                n++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout addr=0x%0h not accepted within 50 cycles", addr);
        end
    endtask

    task automatic check_resp(input string name, input int idx, input int exp_cyc,
                              input logic [31:0] exp_data, input logic exp_err);
        if (idx >= got.size()) begin
            checks++;
            errors++;
            $display("FAIL %s missing response actual_count=%0d required_index=%0d",
                     name, got.size(), idx);
        end else begin
            if (exp_cyc >= 0) chk({name, "_cycle"}, got[idx].cyc, exp_cyc);
            chk({name, "_data"}, got[idx].data, exp_data);
            chk({name, "_err"}, 32'(got[idx].err), 32'(exp_err));
        end
    endtask

    task automatic stimulus();
        int a0, a1, a2, n0, w0, c0, r_cyc;
        int bp_acc [4];

        // Reset then idle
        repeat (3) @(negedge clk);
        chk("lit_rst_ready", 32'(req_ready), 32'h0);
        chk("lit_rst_ce", 32'(mem_ce), 32'h0);
        chk("lit_rst_valid", 32'(resp_valid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_rst", 32'(req_ready), 32'h1);
        idle(1);

        // Back-to-back reads
        n0 = got.size();
        issue(1'b0, 32'h40, 32'h0, 4'h0, a0);
        issue(1'b0, 32'h44, 32'h0, 4'h0, a1);
        chk("lit_b2b_second_accept", a1, a0 + 1);
        idle(4);
        check_resp("lit_b2b_r0", n0, a0 + 2, 32'hA5A5_0001, 1'b0);
        check_resp("lit_b2b_r1", n0 + 1, a0 + 3, 32'hA5A5_0002, 1'b0);

        // Full write, zero-enable write, read-back
        n0 = got.size();
        issue(1'b1, 32'h180, 32'h0BAD_BEEF, 4'hF, a0);
        issue(1'b1, 32'h180, 32'hFFFF_FFFF, 4'h0, a1);
        issue(1'b0, 32'h180, 32'h0, 4'h0, a2);
        idle(4);
        check_resp("lit_full_wr_ack", n0, a0 + 1, 32'h0, 1'b0);
        check_resp("lit_be0_readback", n0 + 2, a2 + 2, 32'h0BAD_BEEF, 1'b0);

        // Read immediately followed by a full write: both land in the FIFO together
        n0 = got.size();
        issue(1'b0, 32'h40, 32'h0, 4'h0, a0);
        issue(1'b1, 32'h184, 32'h600D_F00D, 4'hF, a1);
        issue(1'b0, 32'h184, 32'h0, 4'h0, a2);
        idle(4);
        check_resp("lit_mix_rd", n0, a0 + 2, 32'hA5A5_0001, 1'b0);
        check_resp("lit_mix_wr", n0 + 1, a0 + 3, 32'h0, 1'b0);
        check_resp("lit_mix_rb", n0 + 2, -1, 32'h600D_F00D, 1'b0);

        // Partial write via RMW
        n0 = got.size();
        w0 = we_cnt;
        issue(1'b1, 32'h80, 32'hAABB_CCDD, 4'b0101, a0);
        @(negedge clk);
        chk("lit_rmw_ready_n1", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("lit_rmw_ready_n2", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("lit_rmw_ready_n3", 32'(req_ready), 32'h1);
        idle(1);
        chk("lit_rmw_we_cycles", we_cnt - w0, 1);
        chk("lit_rmw_wdata", last_wdata, 32'h11BB_33DD);
        check_resp("lit_rmw_ack", n0, a0 + 3, 32'h0, 1'b0);
        issue(1'b0, 32'h80, 32'h0, 4'h0, a1);
        idle(3);
        check_resp("lit_rmw_readback", n0 + 1, a1 + 2, 32'h11BB_33DD, 1'b0);

        // Backpressure: only two reads fit until responses drain
        n0 = got.size();
        resp_ready = 1'b0;
        r_cyc = -1;
        fork
            for (int i = 0; i < 4; i++) issue(1'b0, 32'hC0 + 32'(i * 4), 32'h0, 4'h0, bp_acc[i]);
            begin
                repeat (6) @(posedge clk);
                #1;
                r_cyc = cyc;
                resp_ready = 1'b1;
            end
        join
        idle(4);
        chk("lit_bp_acc1", bp_acc[1], bp_acc[0] + 1);
        chk("lit_bp_acc2", bp_acc[2], r_cyc + 1);
        chk("lit_bp_acc3", bp_acc[3], r_cyc + 2);
        check_resp("lit_bp_r0", n0, r_cyc, 32'hB000_0000, 1'b0);
        check_resp("lit_bp_r1", n0 + 1, r_cyc + 1, 32'hB000_0001, 1'b0);
        check_resp("lit_bp_r2", n0 + 2, -1, 32'hB000_0002, 1'b0);
        check_resp("lit_bp_r3", n0 + 3, -1, 32'hB000_0003, 1'b0);

        // Out-of-range read
        n0 = got.size();
        c0 = ce_cnt;
        issue(1'b0, 32'h0004_0000, 32'h0, 4'h0, a0);
        idle(3);
        chk("lit_oor_no_ce", ce_cnt - c0, 0);
        check_resp("lit_oor_resp", n0, a0 + 1, 32'h0, 1'b1);

        // Reset asserted during the RMW_RD cycle aborts the write
        n0 = got.size();
        w0 = we_cnt;
        issue(1'b1, 32'h140, 32'h1234_5678, 4'b0011, a0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        chk("lit_rstrmw_no_we", we_cnt - w0, 0);
        chk("lit_rstrmw_no_resp", got.size(), n0);
        issue(1'b0, 32'h140, 32'h0, 4'h0, a1);
        idle(3);
        check_resp("lit_rstrmw_readback", n0, a1 + 2, 32'hCAFE_F00D, 1'b0);
        idle(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b1;
        preload(16'h10, 32'hA5A5_0001);
        preload(16'h11, 32'hA5A5_0002);
        preload(16'h20, 32'h1122_3344);
        preload(16'h50, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) preload(16'h30 + i, 32'hB000_0000 + 32'(i));
        fork
            model_loop();
            stimulus();
            begin
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL watchdog expired after 20000 cycles");
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
